// File: rtl/core_run_pkg.sv
// Shared types and helpers for the core run controller.
// Optional performance counters are enabled with CORE_RUN_PERF_EN.
package core_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOADED = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERFLOW = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_NO_IMAGE = 2'd3
    } err_code_t;

    // Upper bounds for the generic slice helper below.
    localparam int CNT_BUS_MAX = 512;
    localparam int CNT_MAX_W   = 64;

    // Pull core idx's counter out of a flattened per-core bus (zero-extended).
    function automatic logic [CNT_MAX_W-1:0] cnt_slice(input logic [CNT_BUS_MAX-1:0] bus,
                                                       input int idx, input int width);
        logic [CNT_BUS_MAX-1:0] w_mask;
        w_mask = (CNT_BUS_MAX'(1) << width) - CNT_BUS_MAX'(1);
        return CNT_MAX_W'((bus >> (idx * width)) & w_mask);
    endfunction

endpackage

// File: rtl/core_run_channel.sv
// Per-core monitor: end-signal fall/rise tracking, done flag and saturating
// cycle / RAW-stall / flush counters. Perf counters exist only when
// CORE_RUN_PERF_EN is defined; otherwise they read as zero.
module core_run_channel #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_run,
    input  logic                 i_end,
    input  logic                 i_raw,
    input  logic                 i_branch,
    output logic                 o_run,
    output logic                 o_done_next,
    output logic [CNT_WIDTH-1:0] o_cycle,
    output logic [CNT_WIDTH-1:0] o_raw_stall,
    output logic [CNT_WIDTH-1:0] o_flush
);

    logic                 r_end_prev;
    logic                 r_seen_fall;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_cycle;
    logic                 w_fall;
    logic                 w_rise;
    logic                 w_active;

    // A rise only completes the core once a fall has been seen in this run;
    // the rise cycle itself already counts as finished.
    assign w_fall      = i_run && !r_done && r_end_prev && !i_end;
    assign w_rise      = i_run && !r_done && r_seen_fall && !r_end_prev && i_end;
    assign w_active    = i_run && !r_done && !w_rise;
    assign o_run       = i_run && !r_done;
    assign o_done_next = r_done || w_rise;
    assign o_cycle     = r_cycle;

    // Edge tracking, done flag and the run-cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_end_prev  <= 1'b0;
            r_seen_fall <= 1'b0;
            r_done      <= 1'b0;
            r_cycle     <= '0;
        end else begin
            r_end_prev <= i_end;
            if (i_clear) begin
                r_seen_fall <= 1'b0;
                r_done      <= 1'b0;
                r_cycle     <= '0;
            end else begin
                if (w_fall) r_seen_fall <= 1'b1;
                if (w_rise) r_done <= 1'b1;
                if (w_active && r_cycle != '1) r_cycle <= r_cycle + 1'b1;
            end
        end
    end

`ifdef CORE_RUN_PERF_EN
    logic                 r_br_prev;
    logic [CNT_WIDTH-1:0] r_raw_stall;
    logic [CNT_WIDTH-1:0] r_flush;

    assign o_raw_stall = r_raw_stall;
    assign o_flush     = r_flush;

    // Hazard accounting over the same window as the cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_br_prev   <= 1'b0;
            r_raw_stall <= '0;
            r_flush     <= '0;
        end else begin
            r_br_prev <= i_branch;
            if (i_clear) begin
                r_raw_stall <= '0;
                r_flush     <= '0;
            end else if (w_active) begin
                if (i_raw && r_raw_stall != '1) r_raw_stall <= r_raw_stall + 1'b1;
                if (i_branch && !r_br_prev && r_flush != '1) r_flush <= r_flush + 1'b1;
            end
        end
    end
`else
    logic w_unused_hazards;
    assign w_unused_hazards = i_raw ^ i_branch;
    assign o_raw_stall      = '0;
    assign o_flush          = '0;
`endif

endmodule

// File: rtl/core_run_controller.sv
// Program loader and run monitor: streams an image into instruction memory,
// releases the cores and measures each core's run length.
// CORE_RUN_PERF_EN enables the RAW-stall and flush counters.
module core_run_controller
    import core_run_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int INS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_PROG       = 64,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          initial_pc_in,
    input  logic                           load_valid,
    input  logic [INS_WIDTH-1:0]           load_data,
    input  logic                           load_last,
    output logic                           load_ready,
    input  logic                           start_in,
    output logic                           ins_wr_en_out,
    output logic [ADDR_WIDTH-1:0]          ins_wr_addr_out,
    output logic [INS_WIDTH-1:0]           ins_wr_data_out,
    output logic [NUM_CORES-1:0]           core_run_out,
    input  logic [NUM_CORES-1:0]           end_signal_in,
    input  logic [NUM_CORES-1:0]           raw_hazard_in,
    input  logic [NUM_CORES-1:0]           branch_hazard_in,
    output logic [NUM_CORES*CNT_WIDTH-1:0] cycle_count_out,
    output logic [NUM_CORES*CNT_WIDTH-1:0] raw_stall_count_out,
    output logic [NUM_CORES*CNT_WIDTH-1:0] flush_count_out,
    output logic [2:0]                     state_out,
    output logic                           done_out,
    output logic                           error_out,
    output logic [1:0]                     err_code_out
);

    localparam int IDX_W = $clog2(MAX_PROG + 1);
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                 r_state, w_state_next;
    err_code_t              r_err, w_err_next;
    logic [ADDR_WIDTH-1:0]  r_base, w_base_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    logic [RUN_W-1:0]       r_run_cnt;
    logic                   w_load_ready;
    logic                   w_wr_en;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic                   w_clear;
    logic                   w_run;
    logic                   w_timeout;
    logic                   w_all_done;

    logic [NUM_CORES-1:0]                w_core_run;
    logic [NUM_CORES-1:0]                w_done_next;
    logic [NUM_CORES-1:0][CNT_WIDTH-1:0] w_cycle;
    logic [NUM_CORES-1:0][CNT_WIDTH-1:0] w_raw_stall;
    logic [NUM_CORES-1:0][CNT_WIDTH-1:0] w_flush;

    assign w_run      = (r_state == ST_RUN);
    assign w_timeout  = w_run && (r_run_cnt == RUN_W'(TIMEOUT_CYCLES - 1));
    assign w_all_done = &w_done_next;

    // Next-state, load handshake and write strobe.
    always_comb begin
        w_state_next = r_state;
        w_err_next   = r_err;
        w_base_next  = r_base;
        w_idx_next   = r_idx;
        w_load_ready = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_ready = 1'b1;
                if (start_in) begin
                    w_state_next = ST_ERROR;
                    w_err_next   = ERR_NO_IMAGE;
                end else if (load_valid) begin
                    w_wr_en      = 1'b1;
                    w_wr_addr    = initial_pc_in;
                    w_base_next  = initial_pc_in;
                    w_idx_next   = IDX_W'(1);
                    w_state_next = load_last ? ST_LOADED : ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load_ready = 1'b1;
                if (load_valid) begin
                    if (r_idx == IDX_W'(MAX_PROG)) begin
                        w_state_next = ST_ERROR;
                        w_err_next   = ERR_OVERFLOW;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = r_base + ADDR_WIDTH'(r_idx);
                        w_idx_next = r_idx + 1'b1;
                        if (load_last) w_state_next = ST_LOADED;
                    end
                end
            end
            ST_LOADED: begin
                if (start_in) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end
            end
            ST_RUN: begin
                // Completion beats a same-cycle timeout.
                if (w_all_done) begin
                    w_state_next = ST_DONE;
                end else if (w_timeout) begin
                    w_state_next = ST_ERROR;
                    w_err_next   = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (start_in) begin
                    w_state_next = ST_RUN;
                    w_clear      = 1'b1;
                end else if (load_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ERROR: ;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM and load bookkeeping registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_err   <= ERR_NONE;
            r_base  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_err_next;
            r_base  <= w_base_next;
            r_idx   <= w_idx_next;
        end
    end

    // Global run-length counter used only for the timeout.
    always_ff @(posedge clock) begin
        if (reset || w_clear) r_run_cnt <= '0;
        else if (w_run)       r_run_cnt <= r_run_cnt + 1'b1;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_ch
            core_run_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
                .clock       (clock),
                .reset       (reset),
                .i_clear     (w_clear),
                .i_run       (w_run),
                .i_end       (end_signal_in[g]),
                .i_raw       (raw_hazard_in[g]),
                .i_branch    (branch_hazard_in[g]),
                .o_run       (w_core_run[g]),
                .o_done_next (w_done_next[g]),
                .o_cycle     (w_cycle[g]),
                .o_raw_stall (w_raw_stall[g]),
                .o_flush     (w_flush[g])
            );
        end
    endgenerate

    // Handshake outputs are forced low while reset is held.
    assign load_ready          = w_load_ready && !reset;
    assign ins_wr_en_out       = w_wr_en && !reset;
    assign ins_wr_addr_out     = ins_wr_en_out ? w_wr_addr : '0;
    assign ins_wr_data_out     = ins_wr_en_out ? load_data : '0;
    assign core_run_out        = w_core_run;
    assign cycle_count_out     = w_cycle;
    assign raw_stall_count_out = w_raw_stall;
    assign flush_count_out     = w_flush;
    assign state_out           = r_state;
    assign done_out            = (r_state == ST_DONE);
    assign error_out           = (r_state == ST_ERROR);
    assign err_code_out        = r_err;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed/randomized bench for core_run_controller with a behavioural model
// of load addressing and per-core run lengths.
module tb_core_run_controller;
    import core_run_pkg::*;

    localparam int NC  = 2;
    localparam int INS = 32;
    localparam int AW  = 16;
    localparam int MAXP = 16;
    localparam int CW  = 6;
    localparam int TO  = 80;

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     initial_pc_in;
    logic              load_valid, load_last, load_ready, start_in;
    logic [INS-1:0]    load_data;
    logic              ins_wr_en_out;
    logic [AW-1:0]     ins_wr_addr_out;
    logic [INS-1:0]    ins_wr_data_out;
    logic [NC-1:0]     core_run_out, end_signal_in, raw_hazard_in, branch_hazard_in;
    logic [NC*CW-1:0]  cycle_count_out, raw_stall_count_out, flush_count_out;
    logic [2:0]        state_out;
    logic              done_out, error_out;
    logic [1:0]        err_code_out;

    int vectors = 0;
    int miscompares = 0;

    core_run_controller #(
        .NUM_CORES(NC), .INS_WIDTH(INS), .ADDR_WIDTH(AW),
        .MAX_PROG(MAXP), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .initial_pc_in(initial_pc_in),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .start_in(start_in),
        .ins_wr_en_out(ins_wr_en_out), .ins_wr_addr_out(ins_wr_addr_out),
        .ins_wr_data_out(ins_wr_data_out), .core_run_out(core_run_out),
        .end_signal_in(end_signal_in), .raw_hazard_in(raw_hazard_in),
        .branch_hazard_in(branch_hazard_in), .cycle_count_out(cycle_count_out),
        .raw_stall_count_out(raw_stall_count_out), .flush_count_out(flush_count_out),
        .state_out(state_out), .done_out(done_out), .error_out(error_out),
        .err_code_out(err_code_out)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] cnt_of(input logic [NC*CW-1:0] bus, input int i);
        return cnt_slice(CNT_BUS_MAX'(bus), i, CW);
    endfunction

    // Stream n beats from base pc; expected address is pc + beat index.
    task automatic do_load(input logic [AW-1:0] pc, input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                load_valid = 1'b0;
                load_data  = $urandom;
                #1;
                chk("gap_wr_en", 64'(ins_wr_en_out), 64'd0);
                chk("gap_ready", 64'(load_ready), 64'd1);
                tick;
            end
            load_valid    = 1'b1;
            load_data     = $urandom;
            load_last     = (k == n - 1);
            initial_pc_in = (k == 0) ? pc : AW'($urandom);
            #1;
            chk("wr_en", 64'(ins_wr_en_out), 64'd1);
            chk("wr_addr", 64'(ins_wr_addr_out), 64'(AW'(pc + AW'(k))));
            chk("wr_data", 64'(ins_wr_data_out), 64'(load_data));
            tick;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        #1;
        chk("loaded_state", 64'(state_out), 64'(ST_LOADED));
        chk("loaded_ready", 64'(load_ready), 64'd0);
    endtask

    // Run from LOADED/DONE: core i falls at RUN cycle f[i], rises at r[i].
    task automatic do_run(input int f0, input int r0, input int f1, input int r1);
        int f[NC], r[NC], exp_raw[NC], exp_fl[NC], last;
        bit br_prev[NC];
        logic [NC-1:0] exp_run;
        f[0] = f0; r[0] = r0; f[1] = f1; r[1] = r1;
        last = (r0 > r1) ? r0 : r1;
        for (int i = 0; i < NC; i++) begin
            exp_raw[i] = 0; exp_fl[i] = 0; br_prev[i] = 1'b0;
        end
        start_in = 1'b1;
        #1;
        tick;
        start_in = 1'b0;
        for (int c = 1; c <= last; c++) begin
            for (int i = 0; i < NC; i++) begin
                end_signal_in[i]    = !(c >= f[i] && c < r[i]);
                raw_hazard_in[i]    = 1'($urandom_range(0, 1));
                branch_hazard_in[i] = 1'($urandom_range(0, 1));
                if (c < r[i]) begin
                    if (raw_hazard_in[i]) exp_raw[i]++;
                    if (branch_hazard_in[i] && !br_prev[i]) exp_fl[i]++;
                end
                br_prev[i] = branch_hazard_in[i];
                exp_run[i] = (c <= r[i]);
            end
            #1;
            chk("run_state", 64'(state_out), 64'(ST_RUN));
            chk("core_run", 64'(core_run_out), 64'(exp_run));
            tick;
        end
        raw_hazard_in    = '0;
        branch_hazard_in = '0;
        #1;
        chk("done_state", 64'(state_out), 64'(ST_DONE));
        chk("done_out", 64'(done_out), 64'd1);
        chk("done_core_run", 64'(core_run_out), 64'd0);
        for (int i = 0; i < NC; i++) begin
            chk("cycle_cnt", cnt_of(cycle_count_out, i), 64'(r[i] - 1));
`ifdef CORE_RUN_PERF_EN
            chk("raw_cnt", cnt_of(raw_stall_count_out, i), 64'(exp_raw[i]));
            chk("flush_cnt", cnt_of(flush_count_out, i), 64'(exp_fl[i]));
`else
            chk("raw_cnt", cnt_of(raw_stall_count_out, i), 64'd0);
            chk("flush_cnt", cnt_of(flush_count_out, i), 64'd0);
`endif
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        load_valid = 1'b0;
        start_in = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        int f0, f1;
        reset = 1'b1; initial_pc_in = '0; load_valid = 1'b0; load_data = '0;
        load_last = 1'b0; start_in = 1'b0; end_signal_in = '1;
        raw_hazard_in = '0; branch_hazard_in = '0;
        tick;
        chk("rst_ready", 64'(load_ready), 64'd0);
        tick;
        reset = 1'b0;
        #1;
        chk("rst_state", 64'(state_out), 64'(ST_IDLE));
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_err", 64'({error_out, err_code_out}), 64'd0);
        chk("rst_core_run", 64'(core_run_out), 64'd0);
        chk("rst_cycles", 64'(cycle_count_out), 64'd0);
        chk("idle_ready", 64'(load_ready), 64'd1);

        // Image at pc 14, 15 beats, then the reference run.
        do_load(AW'(14), 15, 1'b1);
        do_run(2, 40, 3, 25);

        // Random re-run of the same image.
        f0 = $urandom_range(1, 10);
        f1 = $urandom_range(1, 10);
        do_run(f0, f0 + $urandom_range(1, 50), f1, f1 + $urandom_range(1, 50));

        // DONE -> IDLE on a beat, then a fresh random image and run.
        load_valid = 1'b1;
        #1;
        chk("done_beat_noacc", 64'(ins_wr_en_out), 64'd0);
        tick;
        chk("back_idle", 64'(state_out), 64'(ST_IDLE));
        do_load(AW'($urandom), $urandom_range(1, MAXP), 1'b1);
        f0 = $urandom_range(1, 10);
        f1 = $urandom_range(1, 10);
        do_run(f0, f0 + $urandom_range(1, 50), f1, f1 + $urandom_range(1, 50));

        // Reset in the middle of a load.
        tick;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
            initial_pc_in = AW'(16'h100);
            tick;
        end
        reset = 1'b1;
        #1;
        chk("midrst_wr_en", 64'(ins_wr_en_out), 64'd0);
        tick;
        reset = 1'b0;
        load_valid = 1'b0;
        #1;
        chk("midrst_state", 64'(state_out), 64'(ST_IDLE));
        chk("midrst_cycles", 64'(cycle_count_out), 64'd0);
        chk("midrst_flags", 64'({done_out, error_out, err_code_out, core_run_out}), 64'd0);
        do_load(AW'(16'h2A0), 5, 1'b0);

        // Timeout: ends never fall; counters saturate at 2^CW-1.
        start_in = 1'b1;
        #1;
        tick;
        start_in = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            if (c == 1 || c == TO) begin
                #1;
                chk("to_run_state", 64'(state_out), 64'(ST_RUN));
            end
            tick;
        end
        #1;
        chk("to_state", 64'(state_out), 64'(ST_ERROR));
        chk("to_code", 64'(err_code_out), 64'(ERR_TIMEOUT));
        chk("to_error", 64'(error_out), 64'd1);
        chk("to_core_run", 64'(core_run_out), 64'd0);
        for (int i = 0; i < NC; i++)
            chk("to_sat_cnt", cnt_of(cycle_count_out, i), 64'((1 << CW) - 1));
        tick;
        chk("to_sticky", 64'({error_out, err_code_out}), 64'({1'b1, ERR_TIMEOUT}));

        // Overflow: MAXP+1 beats without last.
        do_reset;
        initial_pc_in = AW'(16'h0F0);
        for (int k = 0; k <= MAXP; k++) begin
            load_valid = 1'b1; load_data = $urandom; load_last = 1'b0;
            #1;
            chk("ov_wr_en", 64'(ins_wr_en_out), 64'(k < MAXP));
            if (k < MAXP) chk("ov_wr_addr", 64'(ins_wr_addr_out), 64'(AW'(16'h0F0 + k)));
            tick;
        end
        load_valid = 1'b0;
        #1;
        chk("ov_state", 64'(state_out), 64'(ST_ERROR));
        chk("ov_code", 64'(err_code_out), 64'(ERR_OVERFLOW));

        // Start with no image.
        do_reset;
        start_in = 1'b1;
        #1;
        tick;
        start_in = 1'b0;
        load_valid = 1'b1;
        #1;
        chk("nl_state", 64'(state_out), 64'(ST_ERROR));
        chk("nl_code", 64'(err_code_out), 64'(ERR_NO_IMAGE));
        chk("nl_no_write", 64'(ins_wr_en_out), 64'd0);
        tick;
        load_valid = 1'b0;
        chk("nl_sticky", 64'({error_out, err_code_out}), 64'({1'b1, ERR_NO_IMAGE}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
- Synthesizable program loader and run monitor for one or more pipelined cores.
- Streams an instruction image into instruction memory starting at a programmable PC.
- Releases the cores, then counts cycles per core until each core's end-signal handshake completes.
- Optionally accumulates RAW-stall and branch-flush counts; sits between the host/bench interface and the SINGLE_CORE instances.

Parameters:
- NUM_CORES, 2, number of monitored cores (channels).
- INS_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, instruction memory address width.
- MAX_PROG, 64, maximum image length in words.
- CNT_WIDTH, 32, width of every counter.
- TIMEOUT_CYCLES, 4096, RUN cycles allowed before an error is raised.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- initial_pc_in  in  ADDR_WIDTH  base address; sampled on the first accepted load beat.
- load_valid  in  1  image beat valid.
- load_data  in  INS_WIDTH  image word.
- load_last  in  1  final beat of the image.
- load_ready  out  1  controller accepts a beat.
- start_in  in  1  one-cycle request to run the loaded image.
- ins_wr_en_out  out  1  instruction memory write strobe.
- ins_wr_addr_out  out  ADDR_WIDTH  write address.
- ins_wr_data_out  out  INS_WIDTH  write data.
- core_run_out  out  NUM_CORES  per-core release (high only in RUN).
- end_signal_in  in  NUM_CORES  per-core end signal.
- raw_hazard_in  in  NUM_CORES  per-core read-after-write hazard flag.
- branch_hazard_in  in  NUM_CORES  per-core control hazard flag.
- cycle_count_out  out  NUM_CORES*CNT_WIDTH  per-core run cycles; core i occupies slice [i*CNT_WIDTH +: CNT_WIDTH].
- raw_stall_count_out  out  NUM_CORES*CNT_WIDTH  per-core RAW stall cycles.
- flush_count_out  out  NUM_CORES*CNT_WIDTH  per-core control hazards.
- state_out  out  3  FSM state encoding.
- done_out  out  1  all cores finished.
- error_out  out  1  sticky error.
- err_code_out  out  2  0 none, 1 image overflow, 2 timeout, 3 start before load.

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0; word index 0.
  - Reset applies on any clock edge, including mid-LOAD or mid-RUN.
  - A partial image is abandoned, and core_run_out drops on the same edge.
- FSM states: IDLE, LOAD, LOADED, RUN, DONE, ERROR.
- IDLE:
  - load_ready=1.
  - An accepted beat (valid&ready) latches initial_pc_in as the base and writes word 0.
  - If load_last is also set on that beat, go to LOADED; otherwise go to LOAD.
  - start_in in IDLE: go to ERROR with code 3.
- LOAD:
  - load_ready=1.
  - Each accepted beat k writes ins_wr_addr_out=base+k in the same cycle (combinational strobe from the handshake; zero latency).
  - The beat with load_last goes to LOADED.
  - If beat index k reaches MAX_PROG: do not write; go to ERROR with code 1.
  - load_valid low: hold.
- LOADED:
  - load_ready=0.
  - start_in: go to RUN on the next edge.
  - New beats are not accepted.
- RUN:
  - core_run_out = ~core_done, per core.
  - cycle counter i increments every RUN cycle while core i is not done. The first RUN cycle counts as 1.
  - Core i is done after end_signal_in[i] has fallen and then later risen while in RUN (registered edge detect).
    - The rising edge cycle is not counted.
    - A rise with no prior fall is ignored.
  - When all cores are done: go to DONE and assert done_out.
  - Global RUN cycle counter reaching TIMEOUT_CYCLES: go to ERROR with code 2. Counters freeze.
  - Simultaneous completion of the last core and timeout: DONE wins.
- Counters saturate at all-ones; there is no wrap-around.
- DONE:
  - done_out=1; counters hold.
  - start_in: back to RUN with counters cleared and the same image (re-run).
  - load_valid: back to the IDLE load path; the beat is accepted next cycle.
- ERROR:
  - error_out and err_code_out are sticky. Only reset exits.

Optional Feature:
- CORE_RUN_PERF_EN defined:
  - raw_stall_count[i] increments each RUN cycle with raw_hazard_in[i]=1 while core i is not done.
  - flush_count[i] increments on each rising edge of branch_hazard_in[i].
- Undefined: both buses tied to 0; hazard inputs unused.

Decomposition:
- Package core_run_pkg holds:
  - the state enum;
  - the err_code enum;
  - a helper to extract core i's CNT_WIDTH slice.
- One sub-module: core_run_channel, instantiated NUM_CORES times. It contains:
  - end-signal edge detect;
  - the done flag;
  - saturating cycle, stall and flush counters.

Test Plan:
- Image load: initial_pc_in=14, 15 beats with last on the 15th → writes to addr 14..28 with matching data; state LOADED; load_ready=0.
- Overflow: MAX_PROG=4, 5 beats with no last → 4 writes (addr base..base+3), then ERROR with err_code 1; fifth beat produces no write.
- Run: after load, start. Core0 end falls on RUN cycle 2 and rises on cycle 40; core1 falls on 3 and rises on 25 → cycle counts 39 and 24; done_out is asserted on the cycle after core0 rises.
- Perf (CORE_RUN_PERF_EN): core0 raw_hazard high 3 cycles, branch_hazard pulsed twice → raw_stall 3, flush 2; without the macro both are 0.
- Timeout: TIMEOUT_CYCLES=50, end never rises → ERROR with code 2 at RUN cycle 50; core_run_out=0.
- Reset mid-LOAD after 3 beats → all outputs 0, state IDLE; a new load starts at the newly sampled initial_pc_in.
